// File: rtl/systolic_host_seq.sv
// Sole ibus master for the systolic array: loads A/B operands, kicks the run,
// polls for completion and streams the result words out through a 2-entry skid buffer.
module systolic_host_seq #(
   parameter logic [15:0] A_BASE   = 16'h0000,
   parameter logic [15:0] B_BASE   = 16'h0100,
   parameter logic [15:0] S_BASE   = 16'h0200,
   parameter logic [15:0] CTRL_ADR = 16'h0300,
   parameter logic [15:0] STAT_ADR = 16'h0301,
   parameter int          N_A      = 8,
   parameter int          N_B      = 8,
   parameter int          N_S      = 4,
   parameter int          POLL_MAX = 1023
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [7:0]  cmd_cntr,
   input  logic        din_valid,
   output logic        din_ready,
   input  logic [15:0] din,
   output logic        dout_valid,
   input  logic        dout_ready,
   output logic [15:0] dout,
   output logic        dout_last,
   output logic        busy,
   output logic        done,
   output logic        timeout_err,
   output logic        ren,
   output logic [15:0] ibus_radr,
   input  logic [15:0] ibus_rdata,
   output logic        wen,
   output logic [15:0] ibus_wadr,
   output logic [15:0] ibus_wdata
);

   localparam logic [8:0]  A_LAST    = 9'(N_A - 1);
   localparam logic [8:0]  B_LAST    = 9'(N_B - 1);
   localparam logic [8:0]  S_CNT     = 9'(N_S);
   localparam logic [8:0]  S_LAST    = 9'(N_S - 1);
   localparam logic [15:0] POLL_LAST = 16'(POLL_MAX - 1);

   typedef enum logic [2:0] {IDLE, LOADA, LOADB, KICK, POLL, WAITP, RDS} state_t;

   state_t      state, state_nxt;
   logic [8:0]  idx, idx_nxt;
   logic [7:0]  cntr;
   logic [15:0] poll_cnt, poll_nxt;
   logic        rd_pend;
   logic [15:0] sbuf [2];
   logic        wr_ptr, rd_ptr;
   logic [1:0]  occ;
   logic [8:0]  out_cnt;
   logic        wen_nxt, ren_nxt, done_nxt, tout_set, cmd_accept;
   logic [15:0] wadr_nxt, wdata_nxt, radr_nxt;
   logic        din_fire, pop, push, can_issue;
   logic [2:0]  in_use;

   assign cmd_ready  = (state == IDLE);
   assign busy       = (state != IDLE);
   assign din_ready  = (state == LOADA) || (state == LOADB);
   assign din_fire   = din_valid && din_ready;
   assign cmd_accept = cmd_valid && cmd_ready;
   assign dout_valid = (occ != 2'd0);
   assign dout       = sbuf[rd_ptr];
   assign dout_last  = dout_valid && (out_cnt == S_LAST);
   assign pop        = dout_valid && dout_ready;
   assign push       = (state == RDS) && rd_pend;

   // Buffer slots already claimed: stored words plus reads still on the bus.
   assign in_use    = {1'b0, occ} + {2'b0, ren} + {2'b0, rd_pend} - {2'b0, pop};
   assign can_issue = (state == RDS) && (idx < S_CNT) && (in_use < 3'd2);

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      poll_nxt  = poll_cnt;
      wen_nxt   = 1'b0;
      wadr_nxt  = ibus_wadr;
      wdata_nxt = ibus_wdata;
      ren_nxt   = 1'b0;
      radr_nxt  = ibus_radr;
      done_nxt  = 1'b0;
      tout_set  = 1'b0;
      unique case (state)
         IDLE: begin
            if (cmd_valid) begin
               idx_nxt   = 9'd0;
               poll_nxt  = 16'd0;
               state_nxt = LOADA;
            end
         end
         LOADA: begin
            if (din_fire) begin
               wen_nxt   = 1'b1;
               wadr_nxt  = A_BASE + {7'd0, idx};
               wdata_nxt = din;
               if (idx == A_LAST) begin
                  idx_nxt   = 9'd0;
                  state_nxt = LOADB;
               end else begin
                  idx_nxt = idx + 9'd1;
               end
            end
         end
         LOADB: begin
            if (din_fire) begin
               wen_nxt   = 1'b1;
               wadr_nxt  = B_BASE + {7'd0, idx};
               wdata_nxt = din;
               if (idx == B_LAST) begin
                  idx_nxt   = 9'd0;
                  state_nxt = KICK;
               end else begin
                  idx_nxt = idx + 9'd1;
               end
            end
         end
         KICK: begin
            wen_nxt   = 1'b1;
            wadr_nxt  = CTRL_ADR;
            wdata_nxt = {7'd0, 1'b1, cntr};
            state_nxt = POLL;
         end
         POLL: begin
            ren_nxt   = 1'b1;
            radr_nxt  = STAT_ADR;
            state_nxt = WAITP;
         end
         // Status data arrives the cycle after ren, which is when rd_pend is high.
         WAITP: begin
            if (rd_pend) begin
               if (ibus_rdata[0]) begin
                  idx_nxt   = 9'd0;
                  state_nxt = RDS;
               end else if (poll_cnt == POLL_LAST) begin
                  tout_set  = 1'b1;
                  done_nxt  = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  poll_nxt  = poll_cnt + 16'd1;
                  state_nxt = POLL;
               end
            end
         end
         RDS: begin
            if (can_issue) begin
               ren_nxt  = 1'b1;
               radr_nxt = S_BASE + {7'd0, idx};
               idx_nxt  = idx + 9'd1;
            end else if (idx == S_CNT && occ == 2'd0 && !ren && !rd_pend) begin
               done_nxt  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         idx         <= 9'd0;
         cntr        <= 8'd0;
         poll_cnt    <= 16'd0;
         rd_pend     <= 1'b0;
         wen         <= 1'b0;
         ibus_wadr   <= 16'd0;
         ibus_wdata  <= 16'd0;
         ren         <= 1'b0;
         ibus_radr   <= 16'd0;
         done        <= 1'b0;
         timeout_err <= 1'b0;
         sbuf[0]     <= 16'd0;
         sbuf[1]     <= 16'd0;
         wr_ptr      <= 1'b0;
         rd_ptr      <= 1'b0;
         occ         <= 2'd0;
         out_cnt     <= 9'd0;
      end else begin
         state      <= state_nxt;
         idx        <= idx_nxt;
         poll_cnt   <= poll_nxt;
         rd_pend    <= ren;
         wen        <= wen_nxt;
         ibus_wadr  <= wadr_nxt;
         ibus_wdata <= wdata_nxt;
         ren        <= ren_nxt;
         ibus_radr  <= radr_nxt;
         done       <= done_nxt;
         if (cmd_accept) begin
            cntr        <= cmd_cntr;
            timeout_err <= 1'b0;
            out_cnt     <= 9'd0;
         end else begin
            if (tout_set) timeout_err <= 1'b1;
            if (pop)      out_cnt     <= out_cnt + 9'd1;
         end
         if (push) begin
            sbuf[wr_ptr] <= ibus_rdata;
            wr_ptr       <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         occ <= occ + {1'b0, push} - {1'b0, pop};
      end
   end

endmodule

// File: tb/tb_systolic_host_seq.sv
// Scoreboard bench for systolic_host_seq: a reference model predicts every ibus
// transfer and result word per command; monitors compare them as the DUT produces them.
module tb_systolic_host_seq;

   localparam logic [15:0] A_BASE   = 16'h0000;
   localparam logic [15:0] B_BASE   = 16'h0100;
   localparam logic [15:0] S_BASE   = 16'h0200;
   localparam logic [15:0] CTRL_ADR = 16'h0300;
   localparam logic [15:0] STAT_ADR = 16'h0301;
   localparam int N_A = 8, N_B = 8, N_S = 4, POLL_MAX = 8;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        cmd_valid = 1'b0, cmd_ready;
   logic [7:0]  cmd_cntr = 8'd0;
   logic        din_valid = 1'b0, din_ready;
   logic [15:0] din = 16'd0;
   logic        dout_valid, dout_ready = 1'b1, dout_last;
   logic [15:0] dout;
   logic        busy, done, timeout_err;
   logic        ren, wen;
   logic [15:0] ibus_radr, ibus_rdata = 16'd0, ibus_wadr, ibus_wdata;

   systolic_host_seq #(
      .A_BASE(A_BASE), .B_BASE(B_BASE), .S_BASE(S_BASE), .CTRL_ADR(CTRL_ADR),
      .STAT_ADR(STAT_ADR), .N_A(N_A), .N_B(N_B), .N_S(N_S), .POLL_MAX(POLL_MAX)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_cntr(cmd_cntr),
      .din_valid(din_valid), .din_ready(din_ready), .din(din),
      .dout_valid(dout_valid), .dout_ready(dout_ready), .dout(dout), .dout_last(dout_last),
      .busy(busy), .done(done), .timeout_err(timeout_err),
      .ren(ren), .ibus_radr(ibus_radr), .ibus_rdata(ibus_rdata),
      .wen(wen), .ibus_wadr(ibus_wadr), .ibus_wdata(ibus_wdata)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0, n_bad = 0;
   logic [31:0] exp_wr [$];
   logic [15:0] exp_rd [$];
   logic [16:0] exp_dout [$];
   logic        exp_to = 1'b0;
   int          done_cnt = 0, done_target = 0;
   int          rdy_mode = 0, rdy_k = 0;
   logic [15:0] s_mem [N_S];
   int          stat_reads = 0, stat_limit = 0;
   logic        prev_stall = 1'b0, prev_last = 1'b0;
   logic [15:0] prev_dout = 16'd0;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic note_fail(input string name);
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL %s: unexpected event (t=%0t)", name, $time);
   endtask

   // ibus slave: status reads return 0 until the configured count, then 1.
   always @(posedge clk) begin
      if (ren) begin
         if (ibus_radr == STAT_ADR) begin
            stat_reads = stat_reads + 1;
            ibus_rdata <= {15'($urandom), (stat_reads > stat_limit)};
         end else if (ibus_radr >= S_BASE && ibus_radr < S_BASE + 16'(N_S)) begin
            ibus_rdata <= s_mem[ibus_radr - S_BASE];
         end else begin
            ibus_rdata <= 16'($urandom);
         end
      end else begin
         ibus_rdata <= 16'($urandom);
      end
   end

   always begin
      @(posedge clk);
      #1;
      case (rdy_mode)
         0:       dout_ready = 1'b1;
         1:       dout_ready = (rdy_k % 4 == 0) || (rdy_k % 4 == 3);
         default: dout_ready = 1'($urandom);
      endcase
      rdy_k++;
   end

   // Monitor: pops the scoreboard whenever the DUT presents a transfer.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (wen && ren) note_fail("ren_wen_same_cycle");
         if (wen) begin
            if (exp_wr.size() == 0) note_fail("wen_unexpected");
            else check_output("ibus_write", {ibus_wadr, ibus_wdata}, exp_wr.pop_front());
         end
         if (ren) begin
            if (exp_rd.size() == 0) note_fail("ren_unexpected");
            else check_output("ibus_read_adr", {16'd0, ibus_radr}, {16'd0, exp_rd.pop_front()});
         end
         if (prev_stall)
            check_output("dout_hold", {14'd0, dout_valid, dout_last, dout}, {14'd0, 1'b1, prev_last, prev_dout});
         if (dout_valid && dout_ready) begin
            if (exp_dout.size() == 0) note_fail("dout_unexpected");
            else check_output("dout_word", {15'd0, dout_last, dout}, {15'd0, exp_dout.pop_front()});
         end
         prev_stall = dout_valid && !dout_ready;
         prev_dout  = dout;
         prev_last  = dout_last;
         if (done) begin
            done_cnt++;
            check_output("timeout_flag", {31'd0, timeout_err}, {31'd0, exp_to});
            check_output("reads_left_at_done", exp_rd.size(), 0);
            check_output("dout_left_at_done", exp_dout.size(), 0);
         end
      end
   end

   task automatic apply_stimulus(input logic [7:0] cntr, input int zeros, input int gap,
                                 input int rmode, input bit seq_data, input int abort_after);
      logic [15:0] words [$];
      logic        tmo;
      int          budget;
      for (int i = 0; i < N_A + N_B; i++) words.push_back(seq_data ? 16'(i + 1) : 16'($urandom));
      for (int i = 0; i < N_S; i++) s_mem[i] = seq_data ? 16'hA0 + 16'(i) : 16'($urandom);
      for (int i = 0; i < N_A; i++) exp_wr.push_back({A_BASE + 16'(i), words[i]});
      for (int i = 0; i < N_B; i++) exp_wr.push_back({B_BASE + 16'(i), words[N_A + i]});
      exp_wr.push_back({CTRL_ADR, 16'h0100 | {8'd0, cntr}});
      tmo = (zeros >= POLL_MAX);
      for (int i = 0; i < (tmo ? POLL_MAX : zeros + 1); i++) exp_rd.push_back(STAT_ADR);
      if (!tmo)
         for (int i = 0; i < N_S; i++) begin
            exp_rd.push_back(S_BASE + 16'(i));
            exp_dout.push_back({(i == N_S - 1), s_mem[i]});
         end
      exp_to     = tmo;
      stat_reads = 0;
      stat_limit = zeros;
      rdy_mode   = rmode;
      if (abort_after == 0) done_target++;

      budget = 0;
      do begin @(negedge clk); budget++; end while (!cmd_ready && budget < 100);
      if (!cmd_ready) note_fail("cmd_ready_wait");
      cmd_valid = 1'b1;
      cmd_cntr  = cntr;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      cmd_cntr  = 8'($urandom);
      @(negedge clk);
      check_output("accept_state", {30'd0, busy, timeout_err}, {30'd0, 1'b1, 1'b0});
      @(posedge clk); #1;

      for (int i = 0; i < N_A + N_B; i++) begin
         if (abort_after != 0 && i == abort_after) break;
         repeat (gap) begin din_valid = 1'b0; @(posedge clk); #1; end
         din_valid = 1'b1;
         din       = words[i];
         budget    = 0;
         do begin @(negedge clk); budget++; end while (!din_ready && budget < 100);
         if (!din_ready) note_fail("din_ready_wait");
         @(posedge clk); #1;
      end
      din_valid = 1'b0;

      if (abort_after != 0) begin
         rst_n = 1'b0;
         @(negedge clk);
         check_output("reset_mid_load", {25'd0, cmd_ready, busy, wen, ren, dout_valid, done, din_ready},
                      {25'd0, 7'b1000000});
         repeat (2) @(posedge clk);
         exp_wr.delete();
         exp_rd.delete();
         exp_dout.delete();
         #2 rst_n = 1'b1;
      end else begin
         budget = 0;
         while (done_cnt < done_target && budget < 3000) begin @(negedge clk); budget++; end
         if (done_cnt < done_target) note_fail("done_wait");
         repeat (3) @(negedge clk);
         check_output("done_pulses", done_cnt, done_target);
         check_output("writes_left", exp_wr.size(), 0);
         check_output("idle_after_done", {30'd0, busy, cmd_ready}, {30'd0, 2'b01});
      end
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      @(negedge clk);
      check_output("reset_outputs", {24'd0, cmd_ready, busy, wen, ren, dout_valid, done, timeout_err, din_ready},
                   {24'd0, 8'b10000000});
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      apply_stimulus(8'h07, 5, 0, 0, 1'b1, 0);
      apply_stimulus(8'($urandom), 0, 0, 1, 1'b1, 0);
      apply_stimulus(8'($urandom), 100, 0, 0, 1'b0, 0);
      apply_stimulus(8'($urandom), 2, 0, 2, 1'b0, 0);
      apply_stimulus(8'($urandom), 1, 2, 2, 1'b0, 0);
      apply_stimulus(8'($urandom), 3, 0, 0, 1'b0, 10);
      apply_stimulus(8'($urandom), POLL_MAX - 1, 0, 1, 1'b0, 0);
      repeat (3) apply_stimulus(8'($urandom), int'($urandom_range(0, 4)),
                                int'($urandom_range(0, 2)), 2, 1'b0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
